iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/iter_muldiv.sv | 218 +++++++++++++++++++++
 tb/tb_iter_muldiv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a valid/ready request and result handshake.
module iter_muldiv #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] operand_a,
  input  logic [DW-1:0] operand_b,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_finish;
  logic            w_handoff;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic [DW-1:0]   r_m;
  logic [DW-1:0]   r_result;

  logic            w_is_div;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [DW-1:0]   w_a_mag;
  logic [DW-1:0]   w_b_mag;
  logic            w_div0;
  logic            w_ovf;

  logic [DW:0]     w_sum;
  logic [DW:0]     w_shift;
  logic            w_ge;
  logic [DW-1:0]   w_sub;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_prod_c;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_res_sel;

  function automatic logic [DW-1:0] f_neg(input logic [DW-1:0] x);
    return ~x + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*DW-1:0] f_neg2(input logic [2*DW-1:0] x);
    return ~x + {{(2*DW-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;

  // Operand decode at the accept edge: signedness, magnitudes and early-exit cases.
  assign w_is_div = op[2];
  assign w_a_sgn  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_a_neg  = w_a_sgn & operand_a[DW-1];
  assign w_b_neg  = w_b_sgn & operand_b[DW-1];
  assign w_a_mag  = w_a_neg ? f_neg(operand_a) : operand_a;
  assign w_b_mag  = w_b_neg ? f_neg(operand_b) : operand_b;
  assign w_div0   = w_is_div && (operand_b == {DW{1'b0}});
  assign w_ovf    = ((op == 3'b100) || (op == 3'b110)) &&
                    (operand_a == {1'b1, {(DW-1){1'b0}}}) && (operand_b == {DW{1'b1}});

  // Per-iteration arithmetic; the restoring difference always fits DW bits when taken.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(DW+1){1'b0}});
  assign w_shift = {r_hi, r_lo[DW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});
  assign w_sub   = w_shift[DW-1:0] - r_m;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_c = r_neg_q ? f_neg2(w_prod) : w_prod;
  assign w_quo    = r_neg_q ? f_neg(r_lo) : r_lo;
  assign w_rem    = r_neg_r ? f_neg(r_hi) : r_hi;

  // Final result selection by operation code.
  always_comb begin
    w_res_sel = {DW{1'b0}};
    case (r_op)
      3'b000:                 w_res_sel = w_prod_c[DW-1:0];
      3'b001, 3'b010, 3'b011: w_res_sel = w_prod_c[2*DW-1:DW];
      3'b100, 3'b101:         w_res_sel = w_quo;
      3'b110, 3'b111:         w_res_sel = w_rem;
      default:                w_res_sel = {DW{1'b0}};
    endcase
  end

  // Next-state decode; flush overrides acceptance and handoff.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_handoff   = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_state_nxt = ST_BUSY;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (r_cnt == {CW{1'b0}}) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
            w_handoff   = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: capture at accept, iterate while counting down, register result at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_op     <= 3'b000;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= {DW{1'b0}};
      r_lo     <= {DW{1'b0}};
      r_m      <= {DW{1'b0}};
      r_result <= {DW{1'b0}};
    end else if (flush) begin
      r_cnt    <= {CW{1'b0}};
      r_result <= {DW{1'b0}};
    end else if (w_accept) begin
      r_op <= op;
      if (w_div0) begin
        r_cnt   <= {CW{1'b0}};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
        r_lo    <= {DW{1'b1}};
        r_hi    <= operand_a;
      end else if (w_ovf) begin
        r_cnt   <= {CW{1'b0}};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
        r_lo    <= operand_a;
        r_hi    <= {DW{1'b0}};
      end else begin
        r_cnt   <= CW'(DW);
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_hi    <= {DW{1'b0}};
        r_lo    <= w_is_div ? w_a_mag : w_b_mag;
        r_m     <= w_is_div ? w_b_mag : w_a_mag;
      end
    end else if (w_finish) begin
      r_result <= w_res_sel;
    end else if ((r_state == ST_BUSY) && (r_cnt != {CW{1'b0}})) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op[2]) begin
        if (w_ge) begin
          r_hi <= w_sub;
          r_lo <= {r_lo[DW-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[DW-1:0];
          r_lo <= {r_lo[DW-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[DW:1];
        r_lo <= {w_sum[0], r_lo[DW-1:1]};
      end
    end else if (w_handoff) begin
      r_result <= {DW{1'b0}};
    end else begin
      r_result <= r_result;
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed and randomized scoreboard bench for iter_muldiv at DW=32.
module tb_iter_muldiv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  iter_muldiv #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: if (b == 32'h0) return 32'hFFFFFFFF;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
              else return ia / ib;
      3'b101: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'b110: if (b == 32'h0) return a;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
              else return ia % ib;
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int n;
    logic [31:0] held;
    logic [31:0] e;
    @(negedge clk);
    chk({tag, "_rdy"}, {63'h0, in_ready}, 64'h1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    chk({tag, "_res"}, {32'h0, result}, {32'h0, e});
    held = e;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_res"}, {32'h0, result}, {32'h0, held});
      chk({tag, "_hold_rdy"}, {63'h0, in_ready}, 64'h0);
      chk({tag, "_hold_vld"}, {63'h0, out_valid}, 64'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_post_rdy"}, {63'h0, in_ready}, 64'h1);
    chk({tag, "_post_vld"}, {63'h0, out_valid}, 64'h0);
    chk({tag, "_post_res"}, {32'h0, result}, 64'h0);
    chk({tag, "_post_busy"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          seen;
    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; operand_a = 32'h0; operand_b = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_rdy", {63'h0, in_ready}, 64'h1);
    chk("rst_vld", {63'h0, out_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_res", {32'h0, result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
    run("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1,  0);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run("hold",   3'b101, 32'd1000,     32'd9,        32'd111,      33, 10);

    for (int k = 0; k < 8; k++) begin
      ro = 3'(k);
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run("rand", ro, ra, rb, model(ro, ra, rb), 33, 0);
    end

    // Flush during iteration: no result may ever appear.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b101; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rdy", {63'h0, in_ready}, 64'h1);
    chk("flush_busy", {63'h0, busy}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_novld", 64'(seen), 64'h0);

    // Flush beats acceptance.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'b000; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc_busy", {63'h0, busy}, 64'h0);

    // Flush beats a pending result in DONE.
    in_valid = 1'b1; op = 3'b101; operand_a = 32'd9; operand_b = 32'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_vld", {63'h0, out_valid}, 64'h1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_vld", {63'h0, out_valid}, 64'h0);
    chk("flush_done_res", {32'h0, result}, 64'h0);

    // Asynchronous reset mid-operation, then a normal operation.
    in_valid = 1'b1; op = 3'b000; operand_a = 32'd123; operand_b = 32'd456;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {63'h0, in_ready}, 64'h1);
    chk("arst_vld", {63'h0, out_valid}, 64'h0);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_res", {32'h0, result}, 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run("after_rst", 3'b000, 32'd123, 32'd456, 32'd56088, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
